// File: rtl/param_datapath_pkg.sv
// Shared constants for the parameterised datapath:
// ALU opcodes and the multiply/divide controller states.
package param_datapath_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_MUL = 3'd4;
    localparam logic [2:0] ALU_DIV = 3'd5;
    localparam logic [2:0] ALU_NEG = 3'd6;
    localparam logic [2:0] ALU_NOT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/param_datapath_mul_div.sv
// Iterative signed multiply / divide, one bit per cycle.
// Works on magnitudes and fixes the signs on the final step.
module mul_div_unit
    import param_datapath_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             load,
    output logic             dbz,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    md_state_t          state;
    md_state_t          state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0]   bm;
    logic               neg_q;
    logic               neg_a;
    logic               last;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [WIDTH:0]     r_sh;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH-1:0] div_nxt;
    logic [2*WIDTH-1:0] step;
    logic [2*WIDTH-1:0] step_neg;

    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;
    assign last  = (cnt == CW'(WIDTH - 1));

    // Shift-add: upper half accumulates, lower half holds the multiplier.
    assign mul_sum = {1'b0, p[2*WIDTH-1:WIDTH]}
                   + (p[0] ? {1'b0, bm} : '0);
    assign mul_nxt = {mul_sum, p[WIDTH-1:1]};

    // Restoring divide: p holds {remainder, quotient}.
    assign r_sh = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    assign diff = {1'b0, r_sh} - {2'b00, bm};
    assign div_nxt = diff[WIDTH+1]
                   ? {r_sh[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
                   : {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};

    assign step     = (state == ST_DIV) ? div_nxt : mul_nxt;
    assign step_neg = -step;

    always_ff @(posedge clk) begin
        if (!clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    if (!op_div) begin
                        state_nxt = ST_MUL;
                    end else if (b == '0) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_DIV;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (last) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        load   = 1'b0;
        dbz    = 1'b0;
        res_hi = '0;
        res_lo = '0;
        unique case (state)
            ST_IDLE: begin
                if (start && op_div && b == '0) begin
                    load   = 1'b1;
                    dbz    = 1'b1;
                    res_hi = a;
                    res_lo = '1;
                end
            end
            ST_MUL: begin
                busy = 1'b1;
                load = last;
                {res_hi, res_lo} = neg_q ? step_neg : step;
            end
            ST_DIV: begin
                busy   = 1'b1;
                load   = last;
                res_lo = neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
                res_hi = neg_a ? -step[2*WIDTH-1:WIDTH]
                               : step[2*WIDTH-1:WIDTH];
            end
            ST_DONE: done = 1'b1;
            default: done = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            p     <= '0;
            bm    <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_a <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            p     <= {{WIDTH{1'b0}}, a_mag};
            bm    <= b_mag;
            cnt   <= '0;
            neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_a <= a[WIDTH-1];
        end else if (busy) begin
            p   <= step;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/param_datapath.sv
// Bus-oriented datapath: register file, special registers,
// prioritised bus mux, single-cycle ALU and iterative mul/div.
module param_datapath
    import param_datapath_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 9
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic [$clog2(NUM_REGS)-1:0] reg_sel,
    input  logic                        reg_in,
    input  logic                        reg_out,
    input  logic                        ba_out,
    input  logic                        pc_in,
    input  logic                        pc_out,
    input  logic                        inc_pc,
    input  logic                        y_in,
    input  logic                        z_in,
    input  logic                        zlo_out,
    input  logic                        zhi_out,
    input  logic                        hi_in,
    input  logic                        hi_out,
    input  logic                        lo_in,
    input  logic                        lo_out,
    input  logic                        mar_in,
    input  logic                        mdr_in,
    input  logic                        mdr_out,
    input  logic                        imm_out,
    input  logic                        mem_read,
    input  logic [WIDTH-1:0]            mem_rdata,
    input  logic [WIDTH-1:0]            imm,
    input  logic [2:0]                  alu_op,
    output logic [WIDTH-1:0]            bus,
    output logic [ADDR_W-1:0]           mar_addr,
    output logic [WIDTH-1:0]            mem_wdata,
    output logic                        busy,
    output logic                        done,
    output logic                        div_by_zero,
    output logic                        multi_drive
);

    logic [WIDTH-1:0] gpr [NUM_REGS];
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] zhi;
    logic [WIDTH-1:0] zlo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mdr;
    logic [ADDR_W-1:0] mar;
    logic             dbz_q;

    logic [WIDTH-1:0] reg_val;
    logic [WIDTH-1:0] alu_res;
    logic [7:0]       drv;
    logic             is_md;
    logic             z_ok;
    logic             md_load;
    logic             md_dbz;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    assign reg_val = (ba_out && reg_sel == '0) ? '0 : gpr[reg_sel];

    always_comb begin
        bus = '0;
        priority case (1'b1)
            mdr_out: bus = mdr;
            pc_out:  bus = pc;
            zlo_out: bus = zlo;
            zhi_out: bus = zhi;
            lo_out:  bus = lo;
            hi_out:  bus = hi;
            imm_out: bus = imm;
            reg_out: bus = reg_val;
            default: bus = '0;
        endcase
    end

    assign drv = {mdr_out, pc_out, zlo_out, zhi_out,
                  lo_out, hi_out, imm_out, reg_out};
    assign multi_drive = |(drv & (drv - 8'd1));

    always_comb begin
        alu_res = '0;
        unique case (alu_op)
            ALU_ADD: alu_res = y + bus;
            ALU_SUB: alu_res = y - bus;
            ALU_AND: alu_res = y & bus;
            ALU_OR:  alu_res = y | bus;
            ALU_NEG: alu_res = -bus;
            ALU_NOT: alu_res = ~bus;
            default: alu_res = '0;
        endcase
    end

    assign is_md = (alu_op == ALU_MUL) || (alu_op == ALU_DIV);
    // Z requests are dropped while an iterative op is in flight.
    assign z_ok  = z_in && !busy && !done;

    mul_div_unit #(
        .WIDTH (WIDTH)
    ) u_md (
        .clk    (clk),
        .clr    (clr),
        .start  (z_ok && is_md),
        .op_div (alu_op == ALU_DIV),
        .a      (y),
        .b      (bus),
        .busy   (busy),
        .done   (done),
        .load   (md_load),
        .dbz    (md_dbz),
        .res_hi (md_hi),
        .res_lo (md_lo)
    );

    always_ff @(posedge clk) begin
        if (!clr) begin
            for (int i = 0; i < NUM_REGS; i++) gpr[i] <= '0;
            pc  <= '0;
            y   <= '0;
            hi  <= '0;
            lo  <= '0;
            mar <= '0;
            mdr <= '0;
        end else begin
            if (reg_in) gpr[reg_sel] <= bus;
            if (pc_in) begin
                pc <= bus;
            end else if (inc_pc) begin
                pc <= pc + 1'b1;
            end
            if (y_in)   y   <= bus;
            if (hi_in)  hi  <= bus;
            if (lo_in)  lo  <= bus;
            if (mar_in) mar <= bus[ADDR_W-1:0];
            if (mdr_in) mdr <= mem_read ? mem_rdata : bus;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            zhi   <= '0;
            zlo   <= '0;
            dbz_q <= 1'b0;
        end else begin
            if (md_load) begin
                zhi <= md_hi;
                zlo <= md_lo;
            end else if (z_ok && !is_md) begin
                zhi <= '0;
                zlo <= alu_res;
            end
            if (z_ok) dbz_q <= md_dbz;
        end
    end

    assign mar_addr    = mar;
    assign mem_wdata   = mdr;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_param_datapath.sv
// Directed checks of bus priority, loads, ALU and mul/div timing
// for the default 32-bit configuration.
module tb_param_datapath;
    import param_datapath_pkg::*;

    logic        clk = 1'b0;
    logic        clr;
    logic [3:0]  reg_sel;
    logic        reg_in, reg_out, ba_out;
    logic        pc_in, pc_out, inc_pc, y_in, z_in;
    logic        zlo_out, zhi_out, hi_in, hi_out, lo_in, lo_out;
    logic        mar_in, mdr_in, mdr_out, imm_out, mem_read;
    logic [31:0] mem_rdata, imm;
    logic [2:0]  alu_op;
    logic [31:0] bus, mem_wdata;
    logic [8:0]  mar_addr;
    logic        busy, done, div_by_zero, multi_drive;

    int n_cmp = 0;
    int n_bad = 0;
    int nb;
    int n_done;
    logic [31:0] zh, zl;

    param_datapath dut (
        .clk(clk), .clr(clr), .reg_sel(reg_sel), .reg_in(reg_in),
        .reg_out(reg_out), .ba_out(ba_out), .pc_in(pc_in),
        .pc_out(pc_out), .inc_pc(inc_pc), .y_in(y_in), .z_in(z_in),
        .zlo_out(zlo_out), .zhi_out(zhi_out), .hi_in(hi_in),
        .hi_out(hi_out), .lo_in(lo_in), .lo_out(lo_out),
        .mar_in(mar_in), .mdr_in(mdr_in), .mdr_out(mdr_out),
        .imm_out(imm_out), .mem_read(mem_read), .mem_rdata(mem_rdata),
        .imm(imm), .alu_op(alu_op), .bus(bus), .mar_addr(mar_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .multi_drive(multi_drive)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_strobes();
        reg_sel = '0; reg_in = 0; reg_out = 0; ba_out = 0;
        pc_in = 0; pc_out = 0; inc_pc = 0; y_in = 0; z_in = 0;
        zlo_out = 0; zhi_out = 0; hi_in = 0; hi_out = 0;
        lo_in = 0; lo_out = 0; mar_in = 0; mdr_in = 0; mdr_out = 0;
        imm_out = 0; mem_read = 0; mem_rdata = '0; imm = '0;
        alu_op = ALU_ADD;
    endtask

    task automatic load_y(input logic [31:0] v);
        imm = v; imm_out = 1; y_in = 1;
        tick();
        imm_out = 0; y_in = 0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] v);
        imm = v; imm_out = 1; alu_op = op; z_in = 1;
        tick();
        imm_out = 0; z_in = 0;
    endtask

    task automatic read_z(output logic [31:0] h, output logic [31:0] l);
        zhi_out = 1; #1; h = bus; zhi_out = 0;
        zlo_out = 1; #1; l = bus; zlo_out = 0;
    endtask

    task automatic wait_busy(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        idle_strobes();
        clr = 0;
        tick(); tick();
        clr = 1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_bus", bus, 0);
        check("rst_mar", mar_addr, 0);
        check("rst_mdr", mem_wdata, 0);
        read_z(zh, zl);
        check("rst_zhi", zh, 0);
        check("rst_zlo", zl, 0);

        // R0 and the ba_out qualifier
        imm = 32'h1234; imm_out = 1; reg_in = 1; reg_sel = 0;
        tick();
        imm_out = 0; reg_in = 0;
        reg_out = 1; ba_out = 1; #1;
        check("r0_ba", bus, 0);
        ba_out = 0; #1;
        check("r0_raw", bus, 32'h1234);
        check("r0_single", multi_drive, 0);
        reg_out = 0;

        // MDR from memory, PC load priority, MAR truncation
        mem_rdata = 32'hCAFE; mem_read = 1; mdr_in = 1;
        tick();
        mdr_in = 0; mem_read = 0;
        check("mdr_mem", mem_wdata, 32'hCAFE);
        imm = 32'h40; imm_out = 1; pc_in = 1; inc_pc = 1;
        tick();
        pc_in = 0; inc_pc = 0; imm_out = 0;
        pc_out = 1; #1;
        check("pc_load", bus, 32'h40);
        pc_out = 0;
        inc_pc = 1;
        tick();
        inc_pc = 0;
        pc_out = 1; #1;
        check("pc_inc", bus, 32'h41);
        mdr_out = 1; #1;
        check("pri_bus", bus, 32'hCAFE);
        check("pri_multi", multi_drive, 1);
        pc_out = 0; mdr_out = 0;
        imm = 32'h12345; imm_out = 1; mar_in = 1;
        tick();
        imm_out = 0; mar_in = 0;
        check("mar", mar_addr, 9'h145);

        // single-cycle ALU
        load_y(32'hFFFF_FFFF);
        issue(ALU_ADD, 32'h1);
        check("add_busy", busy, 0);
        check("add_done", done, 0);
        read_z(zh, zl);
        check("add_zhi", zh, 0);
        check("add_zlo", zl, 0);
        load_y(32'd5);
        issue(ALU_SUB, 32'd7);
        read_z(zh, zl);
        check("sub_zlo", zl, 32'hFFFF_FFFE);
        load_y(32'h0000_F0F0);
        issue(ALU_OR, 32'h0000_FF00);
        read_z(zh, zl);
        check("or_zlo", zl, 32'h0000_FFF0);

        // mul 7 * -3 with a z_in and Y change mid-flight
        load_y(32'd7);
        issue(ALU_MUL, 32'hFFFF_FFFD);
        check("mul_busy0", busy, 1);
        nb = 0;
        while (busy === 1'b1 && nb < 100) begin
            if (nb == 5) begin
                imm = 32'd99; imm_out = 1; y_in = 1;
                z_in = 1; alu_op = ALU_ADD;
            end
            tick();
            imm_out = 0; y_in = 0; z_in = 0;
            nb++;
        end
        check("mul_cycles", nb, 32);
        check("mul_done", done, 1);
        read_z(zh, zl);
        check("mul_zhi", zh, 32'hFFFF_FFFF);
        check("mul_zlo", zl, 32'hFFFF_FFEB);
        tick();
        check("mul_done_pulse", done, 0);

        // div -7 / 2
        load_y(32'hFFFF_FFF9);
        issue(ALU_DIV, 32'd2);
        wait_busy(nb);
        check("div_cycles", nb, 32);
        check("div_done", done, 1);
        read_z(zh, zl);
        check("div_zlo", zl, 32'hFFFF_FFFD);
        check("div_zhi", zh, 32'hFFFF_FFFF);
        check("div_nodbz", div_by_zero, 0);
        tick();

        // divide by zero
        load_y(32'd5);
        issue(ALU_DIV, 32'd0);
        check("dbz_busy", busy, 0);
        check("dbz_done", done, 1);
        check("dbz_flag", div_by_zero, 1);
        read_z(zh, zl);
        check("dbz_zlo", zl, 32'hFFFF_FFFF);
        check("dbz_zhi", zh, 32'd5);
        tick();
        check("dbz_done_pulse", done, 0);
        check("dbz_sticky", div_by_zero, 1);
        issue(ALU_ADD, 32'd1);
        check("dbz_cleared", div_by_zero, 0);

        // most-negative / -1
        load_y(32'h8000_0000);
        issue(ALU_DIV, 32'hFFFF_FFFF);
        wait_busy(nb);
        read_z(zh, zl);
        check("ovf_zlo", zl, 32'h8000_0000);
        check("ovf_zhi", zh, 32'h0);
        check("ovf_flag", div_by_zero, 0);
        tick();

        // reset in the middle of a mul
        load_y(32'd3);
        issue(ALU_MUL, 32'd4);
        repeat (9) tick();
        check("mid_busy", busy, 1);
        clr = 0;
        tick();
        clr = 1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        read_z(zh, zl);
        check("abort_zhi", zh, 0);
        check("abort_zlo", zl, 0);
        pc_out = 1; #1;
        check("abort_pc", bus, 0);
        pc_out = 0;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        check("abort_nodone", n_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/param_datapath.md
PARAM_DATAPATH -- requirements
Module: param_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the data and bus width; legal range 8..64, even values only.
REQ-002 SHALL have parameter NUM_REGS, default 16, giving the general-purpose register count (power of 2, at least 2).
REQ-003 SHALL have parameter ADDR_W, default 9, giving the MAR width.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 clr  in  1  reset, synchronous and active-low.
REQ-006 reg_sel  in  $clog2(NUM_REGS)  GPR index; reg_in  in 1  GPR write enable; reg_out  in 1  GPR bus drive; ba_out  in 1  R0-reads-zero qualifier.
REQ-007 pc_in, pc_out, inc_pc, y_in, z_in, zlo_out, zhi_out, hi_in, hi_out, lo_in, lo_out, mar_in, mdr_in, mdr_out, imm_out  in  1 each  register load and bus-drive strobes.
REQ-008 mem_read  in 1  MDR source select; mem_rdata  in WIDTH  memory read data; imm  in WIDTH  pre-extended immediate.
REQ-009 alu_op  in 3  ALU operation: 0 add, 1 sub, 2 and, 3 or, 4 mul, 5 div, 6 neg, 7 not.
REQ-010 bus  out WIDTH  current bus value; mar_addr  out ADDR_W  MAR; mem_wdata  out WIDTH  MDR.
REQ-011 busy  out 1  multicycle op running; done  out 1  one-cycle completion pulse; div_by_zero  out 1  sticky flag; multi_drive  out 1  more than one bus driver asserted this cycle.

Function
REQ-012 Bus SHALL be combinational, priority mdr_out > pc_out > zlo_out > zhi_out > lo_out > hi_out > imm_out > reg_out; 0 when no driver is asserted.
REQ-013 reg_out with reg_sel==0 and ba_out=1 SHALL drive 0 instead of R0.
REQ-014 multi_drive SHALL be 1 whenever two or more drive strobes are high; the bus still follows REQ-012.
REQ-015 Each load SHALL capture the bus on the edge its strobe is high; MDR loads mem_rdata when mem_read=1, else the bus.
REQ-016 MAR SHALL load bus[ADDR_W-1:0].
REQ-017 inc_pc SHALL load PC+1 modulo 2^WIDTH; pc_in takes precedence when both are high.
REQ-018 Single-cycle ops (add, sub, and, or, neg, not) on z_in SHALL load ZLO with f(Y, bus) modulo 2^WIDTH and ZHI with 0 on the same edge; done is not asserted and busy stays 0.
REQ-019 mul SHALL be a signed WIDTH x WIDTH product, with ZHI holding the upper half and ZLO the lower half.
REQ-020 div SHALL be signed, with ZLO = quotient truncated toward zero and ZHI = remainder carrying the dividend's sign; Y is the dividend and the bus is the divisor.
REQ-021 Controller states SHALL be IDLE, MUL, DIV and DONE:
- IDLE: z_in with mul goes to MUL; z_in with div and a nonzero divisor goes to DIV; z_in with div and a zero divisor goes to DONE.
- MUL and DIV: WIDTH cycles, then DONE.
- DONE: one cycle, then IDLE.
REQ-022 Operands SHALL be captured at the start edge; Y and the bus may change while busy without affecting the result.
REQ-023 busy SHALL be high in MUL and DIV; Z SHALL update on entry to DONE; done SHALL be high only in DONE.
REQ-024 Latency: busy is high for exactly WIDTH cycles, and done is seen WIDTH+1 cycles after the start edge.
REQ-025 Divide by zero SHALL set ZLO to all ones, ZHI to the dividend and div_by_zero to 1, with done one cycle after the start edge.
REQ-026 div_by_zero SHALL stay set until the next accepted z_in.
REQ-027 z_in while busy or in DONE SHALL be ignored, with Z unchanged; all other strobes remain live during busy.
REQ-028 The most-negative dividend divided by -1 SHALL give quotient = dividend and remainder 0, with no flag.

Reset
REQ-029 clr=0 on an edge SHALL clear every register (GPRs, PC, IR-free set, Y, ZHI, ZLO, HI, LO, MAR, MDR) to 0, and clear busy, done and div_by_zero to 0.
REQ-030 Reset during MUL or DIV SHALL abort the operation to IDLE with no done pulse; reset overrides every simultaneous strobe.

Structure
REQ-031 Package param_datapath_pkg SHALL hold the alu_op constants and the state encoding.
REQ-032 Iterative multiply and divide SHALL live in the sub-module mul_div_unit (start/busy/done handshake, WIDTH parameter); the top level holds the registers, bus mux and single-cycle ALU.

Verification (WIDTH=32)
REQ-033 mul: Y=7, bus=-3 -> busy for 32 cycles; done on cycle 33; ZHI=0xFFFFFFFF, ZLO=0xFFFFFFEB.
REQ-034 div: Y=-7, bus=2 -> ZLO=0xFFFFFFFD, ZHI=0xFFFFFFFF. Div: Y=5, bus=0 -> done next cycle, ZLO=0xFFFFFFFF, ZHI=5, div_by_zero=1.
REQ-035 Bus and R0: R0=0x1234 with reg_out, reg_sel=0 -> with ba_out=1 the bus reads 0; with ba_out=0 it reads 0x1234. With pc_out and mdr_out both high -> bus=MDR, multi_drive=1.
REQ-036 Ordering: add Y=0xFFFFFFFF, bus=1 -> ZLO=0, ZHI=0. z_in issued mid-mul -> ignored, and the original product is still delivered.
REQ-037 Reset: clr=0 at cycle 10 of a mul -> busy=0 next cycle, Z=0, no done pulse. inc_pc with pc_in at bus=0x40 -> PC=0x40.
